decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_onehot.sv | 17 +
 rtl/decoder.sv | 67 ++++++
 tb/tb_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the binary-to-one-hot decoder.
// The optional change detector in decoder is enabled by defining DECODER_CHG_DET_EN.
package decoder_pkg;

    localparam int unsigned ENCODE_WIDTH_DEF = 2;
    localparam int unsigned ENCODE_WIDTH_MAX = 8;
    localparam int unsigned DECODE_WIDTH_MAX = 1 << ENCODE_WIDTH_MAX;

    function automatic int unsigned decode_width(input int unsigned encode_width);
        return 32'(1) << encode_width;
    endfunction

    // A shift by an unknown amount yields all-X in simulation, and it synthesises to a plain decoder.
    function automatic logic [DECODE_WIDTH_MAX-1:0] onehot_vec(input logic [ENCODE_WIDTH_MAX-1:0] code);
        return DECODE_WIDTH_MAX'(1) << code;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Purely combinational binary-to-one-hot core.
// It is sized by ENCODE_WIDTH and truncates the package helper's result to DECODE_WIDTH bits.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int unsigned ENCODE_WIDTH = ENCODE_WIDTH_DEF,
    parameter int unsigned DECODE_WIDTH = decode_width(ENCODE_WIDTH)
) (
    input  logic [ENCODE_WIDTH-1:0] code,
    output logic [DECODE_WIDTH-1:0] onehot_c
);

    always_comb begin
        onehot_c = DECODE_WIDTH'(onehot_vec(ENCODE_WIDTH_MAX'(code)));
    end

endmodule

// File: rtl/decoder.sv
// Binary decoder with a combinational one-hot output, a registered copy, and an optional change pulse.
// The change pulse is built only when DECODER_CHG_DET_EN is defined; otherwise chg is tied to 0.
module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned ENCODE_WIDTH = ENCODE_WIDTH_DEF,
    parameter int unsigned DECODE_WIDTH = decode_width(ENCODE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ENCODE_WIDTH-1:0] in,
    output logic [DECODE_WIDTH-1:0] out,
    output logic [DECODE_WIDTH-1:0] out_q,
    output logic                    chg
);

    if (ENCODE_WIDTH < 1 || ENCODE_WIDTH > ENCODE_WIDTH_MAX) begin : g_bad_encode_width
        $error("decoder: ENCODE_WIDTH=%0d outside legal range 1..%0d", ENCODE_WIDTH, ENCODE_WIDTH_MAX);
    end

    if (DECODE_WIDTH != decode_width(ENCODE_WIDTH)) begin : g_bad_decode_width
        $error("decoder: DECODE_WIDTH=%0d must equal 2**ENCODE_WIDTH", DECODE_WIDTH);
    end

    logic [DECODE_WIDTH-1:0] out_d;

    decoder_onehot #(
        .ENCODE_WIDTH(ENCODE_WIDTH),
        .DECODE_WIDTH(DECODE_WIDTH)
    ) u_onehot (
        .code    (in),
        .onehot_c(out_d)
    );

    assign out = out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef DECODER_CHG_DET_EN
    logic chg_d;
    logic chg_q;

    // out_q takes out_d at the edge, so a difference now means the loaded value changes.
    always_comb begin
        chg_d = (out_d != out_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign chg = chg_q;
`else
    assign chg = 1'b0;
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder at ENCODE_WIDTH 2 and 3, checked against a code-level reference model.
// chg expectations follow DECODER_CHG_DET_EN.
module tb_decoder;

`ifdef DECODER_CHG_DET_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in2 = 2'd2;
    logic [3:0] out2;
    logic [3:0] out_q2;
    logic       chg2;
    logic [2:0] in3 = 3'd2;
    logic [7:0] out3;
    logic [7:0] out_q3;
    logic       chg3;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last loaded code (-1 = nothing loaded since reset) and the pending change pulse.
    int code2  = -1;
    int code3  = -1;
    bit pulse2 = 1'b0;
    bit pulse3 = 1'b0;

    logic [7:0] step_tab [4] = '{8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000};

    always #5 clk = ~clk;

    decoder #(.ENCODE_WIDTH(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .in   (in2),
        .out  (out2),
        .out_q(out_q2),
        .chg  (chg2)
    );

    decoder #(.ENCODE_WIDTH(3)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .in   (in3),
        .out  (out3),
        .out_q(out_q3),
        .chg  (chg3)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] onehot_of(input int code);
        logic [7:0] v;
        v = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (b == code) v[b] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            code2  = -1;
            code3  = -1;
            pulse2 = 1'b0;
            pulse3 = 1'b0;
        end else begin
            pulse2 = (code2 != int'(in2));
            pulse3 = (code3 != int'(in3));
            code2  = int'(in2);
            code3  = int'(in3);
        end
    end

    always @(negedge clk) begin
        check("m_out2",   8'(out2),   onehot_of(int'(in2)));
        check("m_out_q2", 8'(out_q2), onehot_of(code2));
        check("m_chg2",   8'(chg2),   8'(CHG_EN & pulse2));
        check("m_out3",   out3,       onehot_of(int'(in3)));
        check("m_out_q3", out_q3,     onehot_of(code3));
        check("m_chg3",   8'(chg3),   8'(CHG_EN & pulse3));
    end

    initial begin
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_out",   8'(out2),   8'b0000_0100);
            check("rst_out_q", 8'(out_q2), 8'b0000_0000);
            check("rst_chg",   8'(chg2),   8'b0000_0000);
        end
        #1 rst = 1'b0;

        @(posedge clk); #1;
        check("first_out_q2", 8'(out_q2), 8'b0000_0100);
        check("first_chg2",   8'(chg2),   8'(CHG_EN));
        check("first_out_q3", out_q3,     8'b0000_0100);

        for (int i = 0; i < 4; i++) begin
            in2 = 2'(i); #1;
            check("step_out", 8'(out2), step_tab[i]);
            @(posedge clk); #1;
            check("step_out_q", 8'(out_q2), step_tab[i]);
            check("step_chg",   8'(chg2),   8'(CHG_EN));
        end

        repeat (5) begin
            @(posedge clk); #1;
            check("hold_out_q", 8'(out_q2), 8'b0000_1000);
            check("hold_chg",   8'(chg2),   8'b0000_0000);
        end

        in2 = 2'd0;
        @(posedge clk); #1;
        check("wrap2_out_q", 8'(out_q2), 8'b0000_0001);
        check("wrap2_chg",   8'(chg2),   8'(CHG_EN));

        in2 = 2'd1;
        @(posedge clk); #1;
        check("pre_rst_out_q", 8'(out_q2), 8'b0000_0010);
        #2 rst = 1'b1;
        #1;
        check("async_out_q", 8'(out_q2), 8'b0000_0000);
        check("async_chg",   8'(chg2),   8'b0000_0000);
        check("async_out",   8'(out2),   8'b0000_0010);
        in2 = 2'd2; #1;
        check("async_follow", 8'(out2), 8'b0000_0100);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rel_out_q", 8'(out_q2), 8'b0000_0100);
        check("rel_chg",   8'(chg2),   8'(CHG_EN));

        for (int i = 0; i < 9; i++) begin
            in3 = 3'(i % 8); #1;
            check("sweep_out", out3, onehot_of(i % 8));
            @(posedge clk); #1;
            check("sweep_out_q", out_q3, onehot_of(i % 8));
            check("sweep_chg",   8'(chg3), 8'(CHG_EN));
        end
        check("wrap3_out_q", out_q3, 8'b0000_0001);

        repeat (2) @(posedge clk);
        #1;
        check("end_chg3", 8'(chg3), 8'b0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
